// File: rtl/apple2_mem_pkg.sv
// Shared types for the apple2 RAM arbiter: FSM states, access bundle,
// bank encodings and slot-timer constants.
package apple2_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CORE,
    ST_DMA,
    ST_CLR
  } state_e;

  typedef struct packed {
    logic [17:0] addr;
    logic        aux;
    logic        we;
    logic [7:0]  di;
  } mem_req_t;

  localparam logic BANK_MAIN = 1'b0;
  localparam logic BANK_AUX  = 1'b1;

  localparam int          CNT_W       = 5;
  localparam logic [4:0]  CNT_MAX     = 5'd31;
  localparam logic [4:0]  PERIOD_INIT = 5'd14;

endpackage

// File: rtl/apple2_slot_timer.sv
// PHASE_ZERO edge detector and slot counter; tells the arbiter when a
// non-core access can still finish before the next core slot opens.
module apple2_slot_timer
  import apple2_mem_pkg::*;
#(
  parameter int GUARD = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic phase_i,
  output logic core_edge_o,
  output logic dma_window_o
);

  localparam logic [CNT_W:0] GUARD_W = (CNT_W+1)'(GUARD);

  logic             ph_q;
  logic             seen_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W:0]   need;

  assign core_edge_o = phase_i & ~ph_q;

  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    if (core_edge_o) begin
      cnt_d = '0;
      // First edge after reset ends a partial period, keep the default.
      if (seen_q)
        per_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign need         = {1'b0, cnt_q} + GUARD_W;
  assign dma_window_o = need <= {1'b0, per_q};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ph_q   <= 1'b0;
      seen_q <= 1'b0;
      cnt_q  <= '0;
      per_q  <= PERIOD_INIT;
    end else begin
      ph_q  <= phase_i;
      cnt_q <= cnt_d;
      per_q <= per_d;
      if (core_edge_o)
        seen_q <= 1'b1;
    end
  end

endmodule

// File: rtl/apple2_ram_arbiter.sv
// Shares the external main/aux RAM port between the apple2 core, a host
// DMA port and a cold-start clear sweep; the core keeps fixed slot timing.
module apple2_ram_arbiter
  import apple2_mem_pkg::*;
#(
  parameter int          MEM_LAT   = 2,
  parameter int          GUARD     = 4,
  parameter logic [17:0] CLEAR_TOP = 18'h0BFFF,
  parameter logic [7:0]  FILL      = 8'h00
) (
  input  logic        CLK_14M,
  input  logic        RESET_N,
  input  logic        PHASE_ZERO,
  input  logic [17:0] core_addr,
  input  logic        core_we,
  input  logic [7:0]  core_di,
  input  logic        core_aux,
  output logic [15:0] core_do,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [17:0] dma_addr,
  input  logic        dma_aux,
  input  logic [7:0]  dma_di,
  output logic        dma_ack,
  output logic [15:0] dma_do,
  input  logic        clear_start,
  output logic        clear_busy,
  output logic [17:0] mem_addr,
  output logic        mem_we,
  output logic        mem_aux,
  output logic [7:0]  mem_di,
  input  logic [15:0] mem_do
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LW-1:0] LAST = LW'(MEM_LAT - 1);
  localparam logic          ACK_ON_ENTRY = (MEM_LAT == 1);
  localparam logic [18:0]   PTR_END = {CLEAR_TOP, BANK_AUX};

  state_e          state_q, state_d;
  mem_req_t        req_d;
  logic [LW-1:0]   lat_q;
  logic [17:0]     mem_addr_q;
  logic            mem_we_q;
  logic            mem_aux_q;
  logic [7:0]      mem_di_q;
  logic            core_pend_q;
  logic [15:0]     core_do_q;
  logic            dma_ack_q;
  logic            busy_q;
  logic [18:0]     ptr_q;
  logic            core_edge;
  logic            dma_window;
  logic            grant_ok;

  apple2_slot_timer #(
    .GUARD (GUARD)
  ) u_timer (
    .clk_i        (CLK_14M),
    .rst_n_i      (RESET_N),
    .phase_i      (PHASE_ZERO),
    .core_edge_o  (core_edge),
    .dma_window_o (dma_window)
  );

  // A slot opening this very cycle also blocks background grants.
  assign grant_ok = ~core_pend_q & ~core_edge & dma_window;

  always_comb begin
    state_d = ST_IDLE;
    req_d   = '0;
    if (core_pend_q) begin
      state_d = ST_CORE;
      req_d   = '{addr: core_addr, aux: core_aux,
                  we: core_we, di: core_di};
    end else if (busy_q && grant_ok) begin
      state_d = ST_CLR;
      req_d   = '{addr: ptr_q[18:1], aux: ptr_q[0],
                  we: 1'b1, di: FILL};
    end else if (dma_req && !busy_q && grant_ok) begin
      state_d = ST_DMA;
      req_d   = '{addr: dma_addr, aux: dma_aux,
                  we: dma_we, di: dma_di};
    end
  end

  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      lat_q       <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_aux_q   <= BANK_MAIN;
      mem_di_q    <= '0;
      core_pend_q <= 1'b0;
      core_do_q   <= '0;
      dma_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      ptr_q       <= '0;
    end else begin
      dma_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          lat_q <= '0;
          if (state_d != ST_IDLE) begin
            state_q    <= state_d;
            mem_addr_q <= req_d.addr;
            mem_aux_q  <= req_d.aux;
            mem_we_q   <= req_d.we;
            mem_di_q   <= req_d.di;
            dma_ack_q  <= (state_d == ST_DMA) && ACK_ON_ENTRY;
            if (state_d == ST_CORE)
              core_pend_q <= 1'b0;
          end
        end
        default: begin
          if (lat_q == LAST) begin
            state_q  <= ST_IDLE;
            mem_we_q <= 1'b0;
            lat_q    <= '0;
            if (state_q == ST_CORE && !mem_we_q)
              core_do_q <= mem_do;
            if (state_q == ST_CLR) begin
              if (ptr_q == PTR_END)
                busy_q <= 1'b0;
              else
                ptr_q <= ptr_q + 19'd1;
            end
          end else begin
            lat_q     <= lat_q + 1'b1;
            dma_ack_q <= (state_q == ST_DMA) &&
                         (lat_q + 1'b1 == LAST);
          end
        end
      endcase
      if (core_edge)
        core_pend_q <= 1'b1;
      if (clear_start) begin
        busy_q <= 1'b1;
        ptr_q  <= '0;
      end
    end
  end

  assign core_do    = core_do_q;
  assign dma_ack    = dma_ack_q;
  assign dma_do     = dma_ack_q ? mem_do : 16'h0000;
  assign clear_busy = busy_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_aux    = mem_aux_q;
  assign mem_di     = mem_di_q;

endmodule

// File: tb/tb_apple2_ram_arbiter.sv
// Directed bench for apple2_ram_arbiter: core slots, DMA windows,
// clear sweep ordering, async reset abort and back-to-back DMA.
module tb_apple2_ram_arbiter;

  logic        CLK_14M;
  logic        RESET_N;
  logic        PHASE_ZERO;
  logic [17:0] core_addr;
  logic        core_we;
  logic [7:0]  core_di;
  logic        core_aux;
  logic [15:0] core_do;
  logic        dma_req;
  logic        dma_we;
  logic [17:0] dma_addr;
  logic        dma_aux;
  logic [7:0]  dma_di;
  logic        dma_ack;
  logic [15:0] dma_do;
  logic        clear_start;
  logic        clear_busy;
  logic [17:0] mem_addr;
  logic        mem_we;
  logic        mem_aux;
  logic [7:0]  mem_di;
  logic [15:0] mem_do;

  int n_chk;
  int n_fail;
  int ph_cnt;
  bit ph_auto;

  apple2_ram_arbiter #(
    .MEM_LAT   (2),
    .GUARD     (4),
    .CLEAR_TOP (18'h0000F),
    .FILL      (8'h00)
  ) dut (
    .CLK_14M     (CLK_14M),
    .RESET_N     (RESET_N),
    .PHASE_ZERO  (PHASE_ZERO),
    .core_addr   (core_addr),
    .core_we     (core_we),
    .core_di     (core_di),
    .core_aux    (core_aux),
    .core_do     (core_do),
    .dma_req     (dma_req),
    .dma_we      (dma_we),
    .dma_addr    (dma_addr),
    .dma_aux     (dma_aux),
    .dma_di      (dma_di),
    .dma_ack     (dma_ack),
    .dma_do      (dma_do),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_aux     (mem_aux),
    .mem_di      (mem_di),
    .mem_do      (mem_do)
  );

  initial begin
    CLK_14M = 1'b0;
    forever #5 CLK_14M = ~CLK_14M;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to the next falling edge; PHASE_ZERO period is 14 cycles,
  // ph_cnt==0 is the tick just before the slot-opening rising edge.
  task automatic tick();
    @(negedge CLK_14M);
    if (ph_auto) begin
      ph_cnt     = (ph_cnt == 13) ? 0 : ph_cnt + 1;
      PHASE_ZERO = (ph_cnt < 7);
    end
  endtask

  task automatic wait_slot(input int k);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (ph_cnt != k && n < 40);
    if (ph_cnt != k) begin
      n_chk++; n_fail++;
      $display("FAIL wait_slot: phase %0d never reached", k);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) tick();
    n_chk++;
    if (mem_we !== 1'b0) begin n_fail++;
      $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    n_chk++;
    if (mem_addr !== 18'h0) begin n_fail++;
      $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    n_chk++;
    if (core_do !== 16'h0) begin n_fail++;
      $display("FAIL rst_core_do: got %h want 0", core_do); end
    n_chk++;
    if ({dma_ack, clear_busy, mem_aux} !== 3'b000) begin n_fail++;
      $display("FAIL rst_flags: got %b want 000",
               {dma_ack, clear_busy, mem_aux}); end
    n_chk++;
    if (dma_do !== 16'h0 || mem_di !== 8'h0) begin n_fail++;
      $display("FAIL rst_data: got %h/%h want 0", dma_do, mem_di); end
    RESET_N = 1'b1;
    repeat (2) tick();
    n_chk++;
    if (mem_we !== 1'b0 || clear_busy !== 1'b0) begin n_fail++;
      $display("FAIL rst_idle: got we=%b busy=%b want 0", mem_we, clear_busy); end
    ph_cnt  = 13;
    ph_auto = 1'b1;
  endtask

  task automatic test_core_read();
    logic [15:0] vals [3];
    logic [15:0] prev;
    int we_hi;
    vals[0] = 16'hA5C3; vals[1] = 16'h3C5A; vals[2] = 16'hA5C3;
    core_addr = 18'h00400; core_we = 1'b0; core_aux = 1'b0;
    prev = 16'h0000;
    we_hi = 0;
    for (int s = 0; s < 3; s++) begin
      wait_slot(0);
      mem_do = vals[s];
      for (int k = 1; k <= 4; k++) begin
        tick();
        if (mem_we) we_hi++;
        if (k == 2) begin
          n_chk++;
          if (mem_addr !== 18'h00400) begin n_fail++;
            $display("FAIL core_addr s%0d: got %h want 00400", s, mem_addr); end
        end
        if (k == 3) begin
          n_chk++;
          if (core_do !== prev) begin n_fail++;
            $display("FAIL core_do_early s%0d: got %h want %h", s, core_do, prev); end
        end
        if (k == 4) begin
          n_chk++;
          if (core_do !== vals[s]) begin n_fail++;
            $display("FAIL core_do s%0d: got %h want %h", s, core_do, vals[s]); end
        end
      end
      prev = vals[s];
    end
    n_chk++;
    if (we_hi !== 0) begin n_fail++;
      $display("FAIL core_no_we: got %0d we cycles want 0", we_hi); end
  endtask

  task automatic test_dma_write();
    int acks, we_hi, at, n;
    logic [17:0] a_addr;
    logic [7:0]  a_di;
    dma_addr = 18'h01234; dma_di = 8'h7E; dma_we = 1'b1; dma_aux = 1'b0;
    wait_slot(0);
    dma_req = 1'b1;
    acks = 0; we_hi = 0; at = -1; a_addr = '0; a_di = '0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (mem_we) we_hi++;
      if (dma_ack) begin
        acks++;
        if (at < 0) begin at = k; a_addr = mem_addr; a_di = mem_di; end
        dma_req = 1'b0;
      end
    end
    n_chk++;
    if (acks !== 1) begin n_fail++;
      $display("FAIL dma_ack_count: got %0d want 1", acks); end
    n_chk++;
    if (at !== 6) begin n_fail++;
      $display("FAIL dma_ack_time: got %0d want 6", at); end
    n_chk++;
    if (we_hi !== 2) begin n_fail++;
      $display("FAIL dma_we_cycles: got %0d want 2", we_hi); end
    n_chk++;
    if (a_addr !== 18'h01234 || a_di !== 8'h7E) begin n_fail++;
      $display("FAIL dma_wr_bus: got %h/%h want 01234/7e", a_addr, a_di); end
    // Raised too late in the slot: must wait for the next slot.
    wait_slot(12);
    dma_req = 1'b1;
    n = 0; at = -1;
    while (at < 0 && n < 30) begin
      tick();
      n++;
      if (dma_ack) begin at = n; dma_req = 1'b0; end
    end
    dma_req = 1'b0;
    n_chk++;
    if (at !== 8) begin n_fail++;
      $display("FAIL dma_guard: got ack after %0d ticks want 8", at); end
  endtask

  task automatic test_dma_in_flight();
    int n;
    dma_addr = 18'h02222; dma_we = 1'b0; mem_do = 16'hBEEF;
    core_addr = 18'h00400; core_we = 1'b0;
    ph_auto = 1'b0;
    PHASE_ZERO = 1'b0;
    repeat (20) tick();
    PHASE_ZERO = 1'b1;
    dma_req = 1'b1;
    tick();
    PHASE_ZERO = 1'b0;
    n = 0;
    while (mem_addr !== 18'h02222 && n < 10) begin tick(); n++; end
    n_chk++;
    if (mem_addr !== 18'h02222) begin n_fail++;
      $display("FAIL inflight_start: got %h want 02222", mem_addr); end
    PHASE_ZERO = 1'b1;
    tick();
    n_chk++;
    if (dma_ack !== 1'b1 || dma_do !== 16'hBEEF) begin n_fail++;
      $display("FAIL inflight_ack: got %b/%h want 1/beef", dma_ack, dma_do); end
    dma_req = 1'b0;
    tick();
    n_chk++;
    if (mem_addr !== 18'h02222 || dma_ack !== 1'b0) begin n_fail++;
      $display("FAIL inflight_hold: got %h/%b want 02222/0", mem_addr, dma_ack); end
    tick();
    n_chk++;
    if (mem_addr !== 18'h00400) begin n_fail++;
      $display("FAIL inflight_core: got %h want 00400", mem_addr); end
    ph_cnt  = 6;
    ph_auto = 1'b1;
    repeat (10) tick();
  endtask

  task automatic test_clear();
    int nw, fell, n;
    bit acked, ack_busy, prev_we;
    dma_addr = 18'h03333; dma_we = 1'b1; dma_di = 8'h55; dma_aux = 1'b1;
    tick();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    dma_req = 1'b1;
    n_chk++;
    if (clear_busy !== 1'b1) begin n_fail++;
      $display("FAIL clr_busy_set: got %b want 1", clear_busy); end
    nw = 0; fell = -1; acked = 0; ack_busy = 0; prev_we = mem_we; n = 0;
    while (!acked && n < 600) begin
      tick();
      n++;
      if (mem_we && !prev_we && mem_di === 8'h00) begin
        n_chk++;
        if (mem_addr !== 18'(nw >> 1) || mem_aux !== nw[0]) begin n_fail++;
          $display("FAIL clr_order %0d: got %h/%b want %h/%b", nw,
                   mem_addr, mem_aux, 18'(nw >> 1), nw[0]); end
        nw++;
      end
      if (!clear_busy && fell < 0) fell = nw;
      if (dma_ack) begin acked = 1; ack_busy = clear_busy; end
      prev_we = mem_we;
    end
    dma_req = 1'b0;
    n_chk++;
    if (nw !== 32) begin n_fail++;
      $display("FAIL clr_count: got %0d want 32", nw); end
    n_chk++;
    if (fell !== 32) begin n_fail++;
      $display("FAIL clr_busy_fall: after %0d writes want 32", fell); end
    n_chk++;
    if (acked !== 1'b1 || ack_busy !== 1'b0) begin n_fail++;
      $display("FAIL clr_dma_after: got acked=%b busy=%b want 1/0",
               acked, ack_busy); end
    repeat (4) tick();
  endtask

  task automatic test_reset_clear();
    int n, we_hi;
    tick();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    n = 0;
    while (!(mem_we && mem_di === 8'h00) && n < 40) begin tick(); n++; end
    n_chk++;
    if (mem_we !== 1'b1) begin n_fail++;
      $display("FAIL rstclr_start: got we=%b want 1", mem_we); end
    RESET_N = 1'b0;
    #1;
    n_chk++;
    if (mem_we !== 1'b0 || clear_busy !== 1'b0) begin n_fail++;
      $display("FAIL rstclr_abort: got we=%b busy=%b want 0/0",
               mem_we, clear_busy); end
    n_chk++;
    if (mem_addr !== 18'h0) begin n_fail++;
      $display("FAIL rstclr_addr: got %h want 0", mem_addr); end
    repeat (2) tick();
    RESET_N = 1'b1;
    we_hi = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (mem_we) we_hi++;
    end
    n_chk++;
    if (we_hi !== 0 || clear_busy !== 1'b0) begin n_fail++;
      $display("FAIL rstclr_idle: got we=%0d busy=%b want 0/0", we_hi, clear_busy); end
  endtask

  task automatic test_back_to_back();
    int acks, we_hi;
    dma_addr = 18'h04444; dma_we = 1'b1; dma_di = 8'h66; dma_aux = 1'b0;
    core_addr = 18'h00400; core_we = 1'b0;
    wait_slot(0);
    dma_req = 1'b1;
    for (int s = 0; s < 3; s++) begin
      acks = 0; we_hi = 0;
      for (int k = 1; k <= 14; k++) begin
        tick();
        if (dma_ack) acks++;
        if (mem_we) we_hi++;
        if (k == 2) begin
          n_chk++;
          if (mem_addr !== 18'h00400) begin n_fail++;
            $display("FAIL b2b_core s%0d: got %h want 00400", s, mem_addr); end
        end
      end
      n_chk++;
      if (acks !== 3) begin n_fail++;
        $display("FAIL b2b_acks s%0d: got %0d want 3", s, acks); end
      n_chk++;
      if (we_hi !== 6) begin n_fail++;
        $display("FAIL b2b_we s%0d: got %0d want 6", s, we_hi); end
    end
    dma_req = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    ph_cnt = 0; ph_auto = 1'b0;
    RESET_N = 1'b0; PHASE_ZERO = 1'b0;
    core_addr = '0; core_we = 1'b0; core_di = 8'h00; core_aux = 1'b0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_aux = 1'b0;
    dma_di = 8'h00; clear_start = 1'b0; mem_do = 16'h0000;
    test_reset();
    test_core_read();
    test_dma_write();
    test_dma_in_flight();
    test_clear();
    test_reset_clear();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
